data_mem_mmio: RTL and testbench
================================

# data_mem_mmio

Memory-stage data memory for the pipelined MIPS core, downstream of the datapath's EX/MEM register. It consumes the memory-stage ALU result (address), store data and write enable, and returns load data to the MEM/WB register in the same cycle. Besides a word-addressed data RAM, it decodes a small memory-mapped peripheral window: GPIO, a free-running cycle counter and a one-shot countdown timer with a sticky interrupt flag.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, 4..4096.
- MMIO_BASE, 32'hFFFF_FF00: base of the 256-byte peripheral window, reachable with a negative offset from $0.
- CLK  input  1  rising-edge clock; one clock, no other clock domains.
- RST  input  1  reset, asynchronous and active-low.
- ALUOut  input  32  byte address, which is the memory-stage ALU result.
- WriteData  input  32  store data.
- MemWrite  input  1  store enable; sampled on the rising edge of CLK.
- ReadData  output  32  load data; combinational from ALUOut.
- gpio_in  input  32  asynchronous external inputs.
- gpio_out  output  32  GPIO output register; reset value 0.
- timer_irq  output  1  level output equal to TIMER_STAT.expired; reset value 0.

## Operation
- Address decode, with ALUOut[1:0] ignored (word access only):
  - RAM when ALUOut < DEPTH*4. Index is ALUOut[log2(DEPTH)+1:2].
  - MMIO when ALUOut[31:8] == MMIO_BASE[31:8]. Offset is ALUOut[7:0].
  - Any other address reads 32'h0 and ignores writes.
- RAM:
  - Asynchronous read; write on the CLK edge when MemWrite is high.
  - Contents are not reset.
- MMIO registers. Unlisted offsets read 0 and ignore writes.
  - 0x00 GPIO_OUT, read/write.
  - 0x04 GPIO_IN, read-only. gpio_in passed through a 2-flop synchronizer; reset value 0.
  - 0x08 CYCLE, read-only. Increments every cycle and wraps from 32'hFFFF_FFFF to 0; reset value 0.
  - 0x0C TIMER_LOAD, read/write. Holds the last value loaded. A write also starts the timer.
  - 0x10 TIMER_CNT, read-only. Current count.
  - 0x14 TIMER_STAT. Bit0 = expired (sticky, write-1-to-clear). Bit1 = running (read-only). Other bits read 0.
- Timer FSM, states IDLE and RUN; reset state is IDLE with CNT=0.
  - IDLE, write LOAD=v with v≠0: CNT←v, go to RUN.
  - IDLE, write LOAD=0: stay in IDLE, CNT←0, expired unchanged.
  - RUN: CNT←CNT-1 each cycle.
  - RUN with CNT==1: CNT←0, expired←1, go to IDLE.
  - RUN, write LOAD=v: restarts with CNT←v, or goes to IDLE if v==0. The restart takes precedence over the decrement and over expiry in the same cycle.
- Simultaneous events:
  - Write-1-to-clear in the same cycle that expiry sets the flag: set wins, expired stays 1.
  - A LOAD write does not clear expired.
- Reset asserted at any time, including mid-count: all registers, the FSM and the synchronizer return to their reset values immediately. RAM contents are kept.

## Timing
- Load latency is 0 cycles. ReadData is valid combinationally in the same cycle as ALUOut and is captured by MEM/WB on the next edge.
- Store latency is 1 edge. A read of the same location in the following cycle returns the new data. A read in the same cycle as the write returns the old data.
- CYCLE read in cycle n returns the pre-edge value, i.e. n cycles since reset release.
- Timer: a LOAD write of v at edge k sets running at k. expired and timer_irq rise at edge k+v, and running falls at the same edge.
- GPIO_IN has 2 cycles of latency from gpio_in to a readable value.
- No stall or handshake: every access completes in one cycle.

## Structure
- Shared package `data_mem_mmio_pkg`:
  - register offset localparams OFF_GPIO_OUT … OFF_TIMER_STAT;
  - STAT bit indices;
  - timer state enum {T_IDLE, T_RUN}.
- One sub-module, `mmio_timer`. It holds the FSM, CNT, LOAD and expired, and takes a load strobe, a clear strobe, the write data and the reset.
- RAM, decode, GPIO, CYCLE and the read mux live in the top level.

## Test plan
- Reset, then read 0x08 at cycle 5 after release → 5. Read 0x14 → 0. gpio_out = 0, timer_irq = 0.
- Store 32'hDEAD_BEEF to 0x10, then load 0x10 the next cycle → DEAD_BEEF. Load 0x13 → DEAD_BEEF. Store to 0x100 with DEPTH=64, then load 0x100 → 0, and RAM word 0 is unchanged.
- Write LOAD=3 at edge k:
  - CNT reads 3, 2, 1 on successive cycles;
  - timer_irq rises at edge k+3 and STAT reads 1;
  - write STAT=1 → timer_irq goes to 0 next edge.
- Write LOAD=10, then LOAD=2 two cycles later → expiry 2 edges after the second write. Issue a STAT clear in the expiry cycle → expired stays 1.
- Write LOAD=8 and assert RST mid-count → immediately CNT=0, running=0, expired=0, gpio_out=0. RAM data written before reset is still readable.
- Drive gpio_in = 32'h0000_00A5 → a read of 0x04 returns A5 from the 3rd cycle onward. Write GPIO_OUT=32'h1234 → gpio_out = 1234 after the edge.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the memory-stage data memory and its peripheral window.
package data_mem_mmio_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] OFF_GPIO_OUT   = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN    = 8'h04;
    localparam logic [7:0] OFF_CYCLE      = 8'h08;
    localparam logic [7:0] OFF_TIMER_LOAD = 8'h0C;
    localparam logic [7:0] OFF_TIMER_CNT  = 8'h10;
    localparam logic [7:0] OFF_TIMER_STAT = 8'h14;

    localparam int unsigned STAT_EXPIRED = 0;
    localparam int unsigned STAT_RUNNING = 1;

    typedef enum logic {
        T_IDLE,
        T_RUN
    } timer_state_e;

endpackage

// File: rtl/mmio_timer.sv
// One-shot countdown timer with a sticky expired flag (write-1-to-clear).
module mmio_timer
    import data_mem_mmio_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] cnt_o,
    output logic              expired_o,
    output logic              running_o
);

    timer_state_e      state_q;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] load_q;
    logic              expired_q;

    // A load overrides both the decrement and expiry; expiry beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= T_IDLE;
            cnt_q     <= '0;
            load_q    <= '0;
            expired_q <= 1'b0;
        end else if (load_i) begin
            load_q  <= wdata_i;
            cnt_q   <= wdata_i;
            state_q <= (wdata_i != '0) ? T_RUN : T_IDLE;
            if (clr_i) expired_q <= 1'b0;
        end else if (state_q == T_RUN) begin
            if (cnt_q == WORD_W'(1)) begin
                cnt_q     <= '0;
                expired_q <= 1'b1;
                state_q   <= T_IDLE;
            end else begin
                cnt_q <= cnt_q - WORD_W'(1);
                if (clr_i) expired_q <= 1'b0;
            end
        end else if (clr_i) begin
            expired_q <= 1'b0;
        end
    end

    assign load_o    = load_q;
    assign cnt_o     = cnt_q;
    assign expired_o = expired_q;
    assign running_o = (state_q == T_RUN);

endmodule

// File: rtl/data_mem_mmio.sv
// Memory-stage data RAM plus GPIO / cycle counter / timer peripheral window.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] gpio_out_q;
    logic [WORD_W-1:0] sync1_q;
    logic [WORD_W-1:0] sync2_q;
    logic [WORD_W-1:0] cycle_q;

    logic              is_ram;
    logic              is_mmio;
    logic [AW-1:0]     ram_idx;
    logic [7:0]        off_w;
    logic              mmio_we;
    logic [WORD_W-1:0] t_load;
    logic [WORD_W-1:0] t_cnt;
    logic              t_expired;
    logic              t_running;
    logic              unused_addr_bits;

    // Byte lanes are ignored: every access is a full word.
    assign is_ram           = (ALUOut[31:AW+2] == '0);
    assign is_mmio          = (ALUOut[31:8] == MMIO_BASE[31:8]);
    assign ram_idx          = ALUOut[AW+1:2];
    assign off_w            = {ALUOut[7:2], 2'b00};
    assign mmio_we          = MemWrite && is_mmio;
    assign unused_addr_bits = &{1'b0, ALUOut[1:0]};

    // RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (MemWrite && is_ram) mem[ram_idx] <= WriteData;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            cycle_q <= cycle_q + WORD_W'(1);
            if (mmio_we && off_w == OFF_GPIO_OUT) gpio_out_q <= WriteData;
        end
    end

    mmio_timer u_timer (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .load_i    (mmio_we && off_w == OFF_TIMER_LOAD),
        .clr_i     (mmio_we && off_w == OFF_TIMER_STAT && WriteData[STAT_EXPIRED]),
        .wdata_i   (WriteData),
        .load_o    (t_load),
        .cnt_o     (t_cnt),
        .expired_o (t_expired),
        .running_o (t_running)
    );

    // Combinational load path; out-of-window addresses read zero.
    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = mem[ram_idx];
        end else if (is_mmio) begin
            case (off_w)
                OFF_GPIO_OUT:   ReadData = gpio_out_q;
                OFF_GPIO_IN:    ReadData = sync2_q;
                OFF_CYCLE:      ReadData = cycle_q;
                OFF_TIMER_LOAD: ReadData = t_load;
                OFF_TIMER_CNT:  ReadData = t_cnt;
                OFF_TIMER_STAT: begin
                    ReadData[STAT_EXPIRED] = t_expired;
                    ReadData[STAT_RUNNING] = t_running;
                end
                default:        ReadData = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = t_expired;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Randomized scoreboard bench for data_mem_mmio against a cycle-indexed reference model.
module tb_data_mem_mmio;

    localparam int DEPTH = 64;
    localparam logic [31:0] MB = 32'hFFFF_FF00;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] ALUOut = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic        timer_irq;

    data_mem_mmio #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALUOut    (ALUOut),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc;

    // Reference model state.
    logic [31:0] mem_m [int];
    logic [31:0] gout, gout_pend, load_m, t_v, g_cur, g_prev, gin_next;
    bit          gout_pv, t_act, exp_m;
    int          t_c, g_chg;

    always @(posedge CLK or negedge RST) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = ReadData;
                1:       act = gpio_out;
                default: act = {31'b0, timer_irq};
            endcase
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s @cyc %0d: got %h expected %h", e.tag, cyc, act, e.val);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int kind, input logic [31:0] val, input string tag);
        exp_t e;
        e.kind = kind; e.val = val; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        gout = '0; gout_pv = 1'b0; load_m = '0;
        t_act = 1'b0; exp_m = 1'b0; t_c = 0; t_v = '0;
    endfunction

    // Expiry at edge load_cycle+1+v becomes visible in that cycle.
    function automatic void t_update(input int n);
        if (t_act && longint'(n) >= longint'(t_c) + 1 + longint'(t_v)) begin
            exp_m = 1'b1;
            t_act = 1'b0;
        end
    endfunction

    function automatic void exp_read(input logic [31:0] a, input int n,
                                     output logic [31:0] e, output bit known);
        known = 1'b1;
        e = '0;
        if (a < 32'(DEPTH * 4)) begin
            known = mem_m.exists(int'(a / 4));
            if (known) e = mem_m[int'(a / 4)];
        end else if (a[31:8] == MB[31:8]) begin
            case (a[7:0] & 8'hFC)
                8'h00: e = gout;
                8'h04: e = (n >= g_chg + 2) ? g_cur : g_prev;
                8'h08: e = 32'(n);
                8'h0C: e = load_m;
                8'h10: e = t_act ? 32'(longint'(t_c) + 1 + longint'(t_v) - longint'(n)) : 32'h0;
                8'h14: e = {30'b0, t_act, exp_m};
                default: e = '0;
            endcase
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] wd, input int n);
        if (a < 32'(DEPTH * 4)) begin
            mem_m[int'(a / 4)] = wd;
        end else if (a[31:8] == MB[31:8]) begin
            case (a[7:0] & 8'hFC)
                8'h00: begin gout_pend = wd; gout_pv = 1'b1; end
                8'h0C: begin load_m = wd; t_c = n; t_v = wd; t_act = (wd != 0); end
                8'h14: if (wd[0]) exp_m = 1'b0;
                default: ;
            endcase
        end
    endfunction

    task automatic do_cycle(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input bit chk, input string tag);
        int n;
        logic [31:0] e;
        bit known;
        @(posedge CLK); #1;
        n = cyc;
        if (gout_pv) begin gout = gout_pend; gout_pv = 1'b0; end
        t_update(n);
        if (gin_next !== g_cur) begin
            g_prev = g_cur; g_cur = gin_next; g_chg = n;
        end
        gpio_in = gin_next; ALUOut = addr; WriteData = wd; MemWrite = we;
        if (chk) begin
            exp_read(addr, n, e, known);
            if (known) push(0, e, tag);
        end
        push(1, gout, "gpio_out");
        push(2, {31'b0, exp_m}, "timer_irq");
        if (we) model_write(addr, wd, n);
    endtask

    task automatic release_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        MemWrite = 1'b0;
        ALUOut = MB + 32'h08;
        model_reset();
        g_prev = '0; g_cur = gin_next; g_chg = 0;
        push(0, 32'h0, "cycle_at_release");
    endtask

    task automatic reset_mid();
        @(posedge CLK); #1;
        RST = 1'b0;
        MemWrite = 1'b0;
        ALUOut = MB + 32'h10;
        push(0, 32'h0, "cnt_in_reset");
        push(1, 32'h0, "gpio_out_in_reset");
        push(2, 32'h0, "irq_in_reset");
        @(posedge CLK); #1;
        ALUOut = MB + 32'h14;
        push(0, 32'h0, "stat_in_reset");
        release_reset();
    endtask

    initial begin
        logic [31:0] a;
        int r, idx;
        gin_next = '0;
        g_cur = '0; g_prev = '0; g_chg = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        release_reset();

        checks++;
        if (gpio_out !== 32'h0) begin
            failures++;
            $display("FAIL direct_gpio_out_reset: got %h", gpio_out);
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL direct_irq_reset: got %b", timer_irq);
        end

        // Cycle counter and idle peripheral state after reset.
        repeat (5) do_cycle(1'b0, MB + 32'h08, '0, 1'b1, "cycle_cnt");
        do_cycle(1'b0, MB + 32'h14, '0, 1'b1, "stat_after_reset");

        // RAM store/load, byte-offset aliasing, and the top boundary.
        do_cycle(1'b1, 32'h0, 32'h0BAD_F00D, 1'b0, "w0");
        do_cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, "w10");
        do_cycle(1'b0, 32'h10, '0, 1'b1, "ram_10");
        do_cycle(1'b0, 32'h13, '0, 1'b1, "ram_13");
        do_cycle(1'b1, 32'h100, 32'h5555_AAAA, 1'b1, "oob_write");
        do_cycle(1'b0, 32'h100, '0, 1'b1, "oob_read");
        do_cycle(1'b0, 32'h0, '0, 1'b1, "ram_0_kept");
        do_cycle(1'b0, 32'hFC, '0, 1'b0, "");

        // One-shot timer with v=3, then write-1-to-clear.
        do_cycle(1'b1, MB + 32'h0C, 32'd3, 1'b0, "load3");
        repeat (4) do_cycle(1'b0, MB + 32'h10, '0, 1'b1, "cnt3");
        do_cycle(1'b0, MB + 32'h14, '0, 1'b1, "stat_expired");
        do_cycle(1'b1, MB + 32'h14, 32'h1, 1'b0, "clr");
        do_cycle(1'b0, MB + 32'h14, '0, 1'b1, "stat_cleared");
        do_cycle(1'b0, MB + 32'h0C, '0, 1'b1, "load_reg");

        // Restart mid-count; clear issued in the expiry cycle must lose.
        do_cycle(1'b1, MB + 32'h0C, 32'd10, 1'b0, "load10");
        do_cycle(1'b0, MB + 32'h10, '0, 1'b1, "cnt10");
        do_cycle(1'b1, MB + 32'h0C, 32'd2, 1'b0, "load2");
        do_cycle(1'b0, MB + 32'h10, '0, 1'b1, "cnt2");
        do_cycle(1'b1, MB + 32'h14, 32'h1, 1'b0, "clr_at_expiry");
        do_cycle(1'b0, MB + 32'h14, '0, 1'b1, "stat_set_wins");

        checks++;
        if (timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL direct_irq_set_wins: got %b", timer_irq);
        end

        do_cycle(1'b1, MB + 32'h0C, 32'd0, 1'b0, "load0");
        do_cycle(1'b0, MB + 32'h14, '0, 1'b1, "stat_after_load0");

        // GPIO input latency and GPIO output write.
        gin_next = 32'h0000_00A5;
        repeat (4) do_cycle(1'b0, MB + 32'h04, '0, 1'b1, "gpio_in");
        do_cycle(1'b1, MB + 32'h00, 32'h1234, 1'b0, "gout_w");
        do_cycle(1'b0, MB + 32'h00, '0, 1'b1, "gout_r");

        checks++;
        if (gpio_out !== 32'h0000_1234) begin
            failures++;
            $display("FAIL direct_gpio_out_write: got %h", gpio_out);
        end

        // Reset during a count; RAM survives.
        do_cycle(1'b1, 32'h20, 32'hCAFE_0001, 1'b0, "w20");
        do_cycle(1'b1, MB + 32'h0C, 32'd8, 1'b0, "load8");
        do_cycle(1'b0, MB + 32'h10, '0, 1'b1, "cnt8");
        reset_mid();

        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL direct_irq_after_reset: got %b", timer_irq);
        end

        do_cycle(1'b0, MB + 32'h10, '0, 1'b1, "cnt_post_reset");
        do_cycle(1'b0, 32'h20, '0, 1'b1, "ram_after_reset");
        do_cycle(1'b0, 32'h10, '0, 1'b1, "ram10_after_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (cyc - g_chg >= 3 && $urandom_range(0, 7) == 0) gin_next = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    idx = $urandom_range(0, 15);
                    do_cycle(1'b1, 32'(idx * 4 + $urandom_range(0, 3)), $urandom, 1'b1, "rnd_ram_w");
                end
                2, 3: begin
                    idx = $urandom_range(0, 15);
                    do_cycle(1'b0, 32'(idx * 4 + $urandom_range(0, 3)), '0, 1'b1, "rnd_ram_r");
                end
                4: do_cycle(1'b1, MB + 32'h00, $urandom, 1'b0, "rnd_gout");
                5: do_cycle(1'b1, MB + 32'h0C, 32'($urandom_range(0, 12)), 1'b0, "rnd_load");
                6: do_cycle(1'b1, MB + 32'h14, $urandom, 1'b0, "rnd_stat");
                7, 8: begin
                    a = MB + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
                    do_cycle(1'b0, a, '0, 1'b1, "rnd_mmio_r");
                end
                default: begin
                    a = $urandom;
                    do_cycle(1'($urandom_range(0, 1)), a, $urandom, 1'b1, "rnd_oob");
                end
            endcase
        end

        @(posedge CLK); #1;
        MemWrite = 1'b0;
        @(negedge CLK); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
